bullet_bill_controller: RTL
===========================

Name: bullet_bill_controller

Overview:
- Sequential stage directly upstream of the graphics generator; produces its bulletBillColor/bulletBillXLoc/bulletBillYLoc inputs.
- Launches one coloured bullet from Blockieee's row, advances it one 40-px cell right per movement period and detects collision with a DDaver cell.
- Reports each hit (grid index, colour-match flag) to the enemy-state owner, which decides whether to clear the DDaver.

Parameters:
- TICKS_PER_CELL, 4, number of frameTick pulses per one-cell advance (1..15).
- LAUNCH_COL, 2, grid column the bullet appears in (column right of Blockieee).
- LAST_COL, 15, rightmost grid column; advancing past it retires the bullet.
- MAX_ROW, 10, highest playable row; row 11 is buffer-land.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frameTick  in  1  one-cycle strobe per frame, the movement time base
- fire  in  1  level/pulse launch request
- fireColor  in  12  RGB444 colour of requested bullet; 0 means no bullet
- blockieee  in  4  Blockieee grid row
- ddavers  in  12 x [0:4][0:5]  DDaver colour grid; 0 means empty cell
- bulletBillColor  out  12  current bullet colour, 0 when no bullet
- bulletBillXLoc  out  4  bullet grid column
- bulletBillYLoc  out  4  bullet grid row
- hitValid  out  1  one-cycle hit pulse
- hitRow  out  3  DDaver row index 0..4, valid with hitValid
- hitCol  out  3  DDaver column index 0..5, valid with hitValid
- hitMatch  out  1  bullet colour equals struck DDaver colour, valid with hitValid
- busy  out  1  high in FLY or HIT

Behaviour:
- One clock (clk); reset synchronous active-high; all outputs registered.
- Reset values: state IDLE, bulletBillColor 0, XLoc 0, YLoc 0, hitValid 0, hitRow 0, hitCol 0, hitMatch 0, busy 0, tick counter 0.
- Reset asserted mid-flight or mid-HIT: next edge returns to reset values; a pending hit pulse is dropped.

States:
- IDLE: accepts launch when fire=1, fireColor!=0 and blockieee<=MAX_ROW. On the next edge: XLoc=LAUNCH_COL, YLoc=blockieee, colour=fireColor, tick counter=0, state FLY. Otherwise fire is ignored.
- FLY, collision check (uses registered position; priority over movement):
  - hit when YLoc odd, YLoc<=9, XLoc even, XLoc>=4, and ddavers[YLoc>>1][(XLoc>>1)-2]!=0.
  - on hit, next edge: state HIT, hitValid=1, hitRow=YLoc>>1, hitCol=(XLoc>>1)-2, hitMatch=(colour==that cell); position and colour held.
- FLY, movement (no hit): on frameTick, counter increments. When counter reaches TICKS_PER_CELL-1 with frameTick, counter clears and:
  - XLoc<LAST_COL: XLoc+1.
  - XLoc==LAST_COL: next state IDLE, colour 0, X 0, Y 0.
- FLY, fire held: ignored; no re-launch and no colour change in flight.
- HIT: lasts exactly one cycle. Next edge: hitValid=0, colour/X/Y=0, state IDLE. A fire in that cycle is ignored; a new launch requires the bullet to be IDLE.
- Hit latency: exactly 1 cycle after the bullet's registered position enters an occupied cell. Position and ddavers changes in the same cycle use the pre-edge ddavers value.
- Arithmetic: XLoc 4-bit and never wraps (retire at LAST_COL). Index math is unsigned; hitRow/hitCol are only computed when the cell predicate holds.

Decomposition:
- Shared package (color_crasher_pkg): BSIZE=40, GRID_COLS=16, GRID_ROWS=12, DDAVER_ROWS=5, DDAVER_COLS=6, ddaver cell-predicate/index function, RGB444 typedef, state enum (IDLE, FLY, HIT).
- Optional sub-module: cell_step_timer (frameTick divider with clear/terminal-count output). Everything else lives in one always_ff plus one always_comb.

Test Plan:
- Reset, then blockieee=3, fire=1, fireColor=12'hF00 -> next cycle busy=1, X=2, Y=3, colour F00. With TICKS_PER_CELL=4, X=3 after the 4th frameTick.
- Empty ddavers grid, row 2 launch -> X steps 2..15, then one cell-period later colour=0, X=0, Y=0, busy=0, hitValid never set.
- ddavers[1][0]=12'hF00, launch row 3 colour F00 -> after the bullet reaches X=4, exactly one cycle of hitValid=1, hitRow=1, hitCol=0, hitMatch=1; next cycle IDLE.
- Same with ddavers[1][0]=12'h0F0 -> hitValid=1, hitMatch=0. Fire held high during flight and during HIT -> no relaunch until after IDLE is reached.
- fire with fireColor=0, or blockieee=11 -> stays IDLE, all outputs 0.
- Reset pulsed while X=9 in FLY -> next cycle all outputs 0; no hitValid.

Source files
------------

// File: rtl/color_crasher_pkg.sv
// Shared Color Crasher definitions: grid geometry, colour type, bullet FSM
// encodings and the DDaver cell lookup used by the bullet controller.
package color_crasher_pkg;

    localparam int BSIZE       = 40;
    localparam int GRID_COLS   = 16;
    localparam int GRID_ROWS   = 12;
    localparam int DDAVER_ROWS = 5;
    localparam int DDAVER_COLS = 6;

    typedef logic [11:0] rgb444_t;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FLY  = 2'd1;
    localparam logic [1:0] HIT  = 2'd2;

    typedef struct packed {
        logic       valid;
        logic [2:0] row;
        logic [2:0] col;
    } cell_idx_t;

    // DDavers occupy odd rows 1..9 and even columns 4..14; indices are zero when not on a cell.
    function automatic cell_idx_t ddaver_cell(input logic [3:0] x, input logic [3:0] y);
        cell_idx_t c;
        c.valid = y[0] && (y <= 4'd9) && !x[0] && (x >= 4'd4);
        if (c.valid) begin
            c.row = y[3:1];
            c.col = x[3:1] - 3'd2;
        end else begin
            c.row = 3'd0;
            c.col = 3'd0;
        end
        return c;
    endfunction

endpackage

// File: rtl/bullet_bill_controller_cell_step_timer.sv
// Divides frameTick down to one terminal pulse per bullet cell advance.
module cell_step_timer #(
    parameter int unsigned TICKS_PER_CELL = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic terminal
);

    localparam logic [3:0] LAST_CNT = 4'(TICKS_PER_CELL - 1);

    logic [3:0] cnt_r;

    assign terminal = tick && (cnt_r == LAST_CNT);

    // Tick counter, held at zero whenever the bullet is not flying.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= 4'd0;
        end else if (clear || terminal) begin
            cnt_r <= 4'd0;
        end else if (tick) begin
            cnt_r <= cnt_r + 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/bullet_bill_controller.sv
// Launches Blockieee's bullet, steps it right across the grid and reports
// the first DDaver cell it strikes to the enemy-state owner.
module bullet_bill_controller
    import color_crasher_pkg::*;
#(
    parameter int unsigned TICKS_PER_CELL = 4,
    parameter int unsigned LAUNCH_COL     = 2,
    parameter int unsigned LAST_COL       = 15,
    parameter int unsigned MAX_ROW        = 10
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           frameTick,
    input  logic                                           fire,
    input  rgb444_t                                        fireColor,
    input  logic [3:0]                                     blockieee,
    input  rgb444_t [0:DDAVER_ROWS-1][0:DDAVER_COLS-1]     ddavers,
    output rgb444_t                                        bulletBillColor,
    output logic [3:0]                                     bulletBillXLoc,
    output logic [3:0]                                     bulletBillYLoc,
    output logic                                           hitValid,
    output logic [2:0]                                     hitRow,
    output logic [2:0]                                     hitCol,
    output logic                                           hitMatch,
    output logic                                           busy
);

    localparam logic [3:0] LAUNCH_COL_C = 4'(LAUNCH_COL);
    localparam logic [3:0] LAST_COL_C   = 4'(LAST_COL);
    localparam logic [3:0] MAX_ROW_C    = 4'(MAX_ROW);

    logic [1:0] state_r, state_s;
    rgb444_t    color_r, color_s;
    logic [3:0] x_r, x_s, y_r, y_s;
    logic       hv_r, hv_s, hmatch_r, hmatch_s, busy_r, busy_s;
    logic [2:0] hrow_r, hrow_s, hcol_r, hcol_s;
    cell_idx_t  cell_s;
    rgb444_t    cell_color_s;
    logic       step_s;
    logic       timer_clear_s;

    assign timer_clear_s = (state_r != FLY);

    cell_step_timer #(
        .TICKS_PER_CELL(TICKS_PER_CELL)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear_s),
        .tick    (frameTick),
        .terminal(step_s)
    );

    // Next-state logic; a collision in FLY takes priority over a cell step.
    always_comb begin
        state_s      = state_r;
        color_s      = color_r;
        x_s          = x_r;
        y_s          = y_r;
        hv_s         = 1'b0;
        hrow_s       = hrow_r;
        hcol_s       = hcol_r;
        hmatch_s     = hmatch_r;
        cell_s       = ddaver_cell(x_r, y_r);
        cell_color_s = ddavers[cell_s.row][cell_s.col];
        case (state_r)
            IDLE: begin
                if (fire && (fireColor != 12'd0) && (blockieee <= MAX_ROW_C)) begin
                    state_s = FLY;
                    x_s     = LAUNCH_COL_C;
                    y_s     = blockieee;
                    color_s = fireColor;
                end else begin
                    state_s = IDLE;
                end
            end
            FLY: begin
                if (cell_s.valid && (cell_color_s != 12'd0)) begin
                    state_s  = HIT;
                    hv_s     = 1'b1;
                    hrow_s   = cell_s.row;
                    hcol_s   = cell_s.col;
                    hmatch_s = (color_r == cell_color_s);
                end else if (step_s) begin
                    if (x_r == LAST_COL_C) begin
                        state_s = IDLE;
                        color_s = 12'd0;
                        x_s     = 4'd0;
                        y_s     = 4'd0;
                    end else begin
                        x_s = x_r + 4'd1;
                    end
                end else begin
                    state_s = FLY;
                end
            end
            HIT: begin
                state_s = IDLE;
                color_s = 12'd0;
                x_s     = 4'd0;
                y_s     = 4'd0;
            end
            default: begin
                state_s = IDLE;
                color_s = 12'd0;
                x_s     = 4'd0;
                y_s     = 4'd0;
            end
        endcase
        busy_s = (state_s == FLY) || (state_s == HIT);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            color_r  <= 12'd0;
            x_r      <= 4'd0;
            y_r      <= 4'd0;
            hv_r     <= 1'b0;
            hrow_r   <= 3'd0;
            hcol_r   <= 3'd0;
            hmatch_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            color_r  <= color_s;
            x_r      <= x_s;
            y_r      <= y_s;
            hv_r     <= hv_s;
            hrow_r   <= hrow_s;
            hcol_r   <= hcol_s;
            hmatch_r <= hmatch_s;
            busy_r   <= busy_s;
        end
    end

    assign bulletBillColor = color_r;
    assign bulletBillXLoc  = x_r;
    assign bulletBillYLoc  = y_r;
    assign hitValid        = hv_r;
    assign hitRow          = hrow_r;
    assign hitCol          = hcol_r;
    assign hitMatch        = hmatch_r;
    assign busy            = busy_r;

endmodule
